// File: rtl/multi_fifo_hs_if.sv
// Handshake bundle for multi_fifo_hs: per-lane push/pop valid/ready, data lanes,
// flush request and occupancy/status observation.
interface multi_fifo_hs_if #(
  parameter int DW    = 32,
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int DEPTH = 12
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              clear;
  logic [M-1:0]      in_valid;
  logic [M*DW-1:0]   in_data;
  logic [M-1:0]      in_ready;
  logic [N-1:0]      out_valid;
  logic [N*DW-1:0]   out_data;
  logic [N-1:0]      out_ready;
  logic [CW-1:0]     count;
  logic [CW-1:0]     free;
  logic [CW-1:0]     hwm;
  logic              err;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, free, hwm, err
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, free, hwm, err
  );
endinterface

// File: rtl/multi_fifo_hs.sv
// Multi-lane push/pop FIFO with per-lane valid/ready, any DEPTH >= 2, sticky
// protocol-error flag and occupancy high-watermark.
// Optional: define MULTI_FIFO_HS_POP_FREES_EN to let same-cycle pops free push slots.
module multi_fifo_hs #(
  parameter int DW    = 32,
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int DEPTH = 12
) (
  input logic             clk,
  input logic             rst_n,
  multi_fifo_hs_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  logic [DW-1:0] mem [DEPTH];

  ptr_t wptr, rptr, wptr_nx, rptr_nx;
  cnt_t count, hwm, count_nx, hwm_nx;
  cnt_t free, free_eff, p, q;
  logic err, err_nx;
  logic in_therm, out_therm;
  logic [M-1:0] in_ready, acc;
  logic [N-1:0] out_valid, pop;

  // base + off is always below 2*DEPTH, so a single conditional subtract wraps it.
  function automatic ptr_t wrap_add(input ptr_t base, input cnt_t off);
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(off);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return PW'(s);
  endfunction

  // NOTE: every signal written in a combinational block gets a default before any branch, so no latch is inferred.
  always_comb begin
    free = cnt_t'(DEPTH) - count;

    pop = '0;
    q   = '0;
    for (int j = 0; j < N; j++) begin
      out_valid[j] = cnt_t'(j) < count;
      pop[j]       = out_valid[j] & bus.out_ready[j];
      q            = q + cnt_t'(pop[j]);
    end

`ifdef MULTI_FIFO_HS_POP_FREES_EN
    // Slots read out this cycle may be refilled by this cycle's pushes.
    free_eff = free + q;
`else
    free_eff = free;
`endif

    acc = '0;
    p   = '0;
    for (int i = 0; i < M; i++) begin
      in_ready[i] = cnt_t'(i) < free_eff;
      acc[i]      = bus.in_valid[i] & in_ready[i];
      p           = p + cnt_t'(acc[i]);
    end

    // Lane vectors must be contiguous from lane 0; a gap is a protocol error.
    in_therm = 1'b1;
    for (int i = 1; i < M; i++)
      if (bus.in_valid[i] && !bus.in_valid[i-1]) in_therm = 1'b0;
    out_therm = 1'b1;
    for (int j = 1; j < N; j++)
      if (bus.out_ready[j] && !bus.out_ready[j-1]) out_therm = 1'b0;

    wptr_nx  = wrap_add(wptr, p);
    rptr_nx  = wrap_add(rptr, q);
    count_nx = count + p - q;
    hwm_nx   = (count_nx > hwm) ? count_nx : hwm;
    err_nx   = err | ~in_therm | ~out_therm;
  end

  always_comb begin
    bus.out_data = '0;
    for (int j = 0; j < N; j++)
      bus.out_data[j*DW +: DW] = mem[wrap_add(rptr, cnt_t'(j))];
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.count     = count;
  assign bus.free      = free;
  assign bus.hwm       = hwm;
  assign bus.err       = err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      hwm   <= '0;
      err   <= 1'b0;
    end else if (bus.clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      hwm   <= '0;
      err   <= 1'b0;
    end else begin
      wptr  <= wptr_nx;
      rptr  <= rptr_nx;
      count <= count_nx;
      hwm   <= hwm_nx;
      err   <= err_nx;
    end
  end

  // NOTE: storage has no reset; entries are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (!bus.clear) begin
      for (int i = 0; i < M; i++)
        if (acc[i]) mem[wrap_add(wptr, cnt_t'(i))] <= bus.in_data[i*DW +: DW];
    end
  end
endmodule

// File: tb/tb_multi_fifo_hs.sv
// Randomized scoreboard bench for multi_fifo_hs (DW=8, M=3, N=2, DEPTH=6): an
// occupancy-level reference model plus an expected-data queue drained by a monitor.
module tb_multi_fifo_hs;
  localparam int DW    = 8;
  localparam int M     = 3;
  localparam int N     = 2;
  localparam int DEPTH = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multi_fifo_hs_if #(.DW(DW), .M(M), .N(N), .DEPTH(DEPTH)) bus ();

  multi_fifo_hs #(.DW(DW), .M(M), .N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected contents, oldest first; -1 marks an entry whose data is undefined.
  int exp_q[$];
  int occ;
  int hwm_m;
  bit err_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit therm(input int v);
    return (v & (v + 1)) == 0;
  endfunction

  // One clock of stimulus: drive at negedge, compare handshake/status, advance the model.
  task automatic cycle(input logic [M-1:0] iv, input logic [M*DW-1:0] d,
                       input logic [N-1:0] ordy, input logic clr);
    int p, q, free_eff;
    logic [M-1:0] exp_rdy, acc;
    logic [N-1:0] exp_ov;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.clear     = clr;
    #1;
    q = 0;
    for (int j = 0; j < N; j++) begin
      exp_ov[j] = j < occ;
      if (exp_ov[j] && ordy[j]) q++;
    end
    free_eff = DEPTH - occ;
`ifdef MULTI_FIFO_HS_POP_FREES_EN
    free_eff = free_eff + q;
`endif
    for (int i = 0; i < M; i++) exp_rdy[i] = i < free_eff;
    check("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    check("count",     32'(bus.count),     occ);
    check("free",      32'(bus.free),      DEPTH - occ);
    check("hwm",       32'(bus.hwm),       hwm_m);
    check("err",       32'(bus.err),       32'(err_m));
    if (rst_n && clr) begin
      occ = 0; hwm_m = 0; err_m = 1'b0;
    end else if (rst_n) begin
      acc = iv & exp_rdy;
      p = 0;
      for (int i = 0; i < M; i++) if (acc[i]) p++;
      for (int k = 0; k < p; k++)
        exp_q.push_back(acc[k] ? int'(d[k*DW +: DW]) : -1);
      occ = occ + p - q;
      if (occ > hwm_m) hwm_m = occ;
      if (!therm(int'(iv)) || !therm(int'(ordy))) err_m = 1'b1;
    end
  endtask

  task automatic idle();
    cycle('0, '0, '0, 1'b0);
  endtask

  task automatic rand_cycle(input bit allow_clear);
    logic [M-1:0] iv;
    logic [N-1:0] ordy;
    logic [M*DW-1:0] d;
    iv   = M'((1 << $urandom_range(0, M)) - 1);
    ordy = N'((1 << $urandom_range(0, N)) - 1);
    for (int i = 0; i < M; i++) d[i*DW +: DW] = DW'($urandom);
    cycle(iv, d, ordy, allow_clear && ($urandom_range(0, 49) == 0));
  endtask

  // Monitor: compare every presented lane against the queue head, retire popped ones.
  initial begin
    int qq;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        qq = 0;
        for (int j = 0; j < N; j++) begin
          if (bus.out_valid[j]) begin
            if (j < exp_q.size()) begin
              if (exp_q[j] >= 0) check("out_data", 32'(bus.out_data[j*DW +: DW]), exp_q[j]);
            end else begin
              check("sb_depth", exp_q.size(), j + 1);
            end
            if (bus.out_ready[j]) qq++;
          end
        end
        if (bus.clear) exp_q.delete();
        else repeat (qq) if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.clear = 1'b0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = '0;
    occ = 0; hwm_m = 0; err_m = 1'b0;
    repeat (2) idle();
    rst_n = 1'b1;

    // Basic push, then fill to full with a partially accepted vector.
    cycle(3'b111, {8'd3, 8'd2, 8'd1}, 2'b00, 1'b0);
    cycle(3'b011, {8'd0, 8'd5, 8'd4}, 2'b00, 1'b0);
    cycle(3'b111, {8'd8, 8'd7, 8'd6}, 2'b00, 1'b0);
    idle();

    // Full FIFO with simultaneous push and pop on every lane.
    cycle(3'b111, {8'd11, 8'd10, 8'd9}, 2'b11, 1'b0);
    idle();

    // Drain, then run push-3/pop-2 traffic through several pointer wraps.
    for (int k = 0; k < 5 && occ > 0; k++) cycle('0, '0, 2'b11, 1'b0);
    for (int k = 0; k < 10; k++)
      cycle(3'b111, {8'(3*k+22), 8'(3*k+21), 8'(3*k+20)}, 2'b11, 1'b0);

    repeat (400) rand_cycle(1'b1);

    // Gap in in_valid sets a sticky error; clear drops its own cycle's pushes.
    cycle('0, '0, '0, 1'b1);
    cycle(3'b101, {8'hc3, 8'hb2, 8'ha1}, 2'b00, 1'b0);
    repeat (3) idle();
    cycle(3'b111, {8'h33, 8'h22, 8'h11}, 2'b00, 1'b1);
    idle();

    // Asynchronous reset mid-traffic with count=4 and err set.
    cycle(3'b101, {8'h46, 8'h45, 8'h44}, 2'b00, 1'b0);
    cycle(3'b011, {8'h00, 8'h48, 8'h47}, 2'b00, 1'b0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count",     32'(bus.count),     0);
    check("async_out_valid", 32'(bus.out_valid), 0);
    check("async_err",       32'(bus.err),       0);
    occ = 0; hwm_m = 0; err_m = 1'b0;
    exp_q.delete();
    repeat (2) idle();
    rst_n = 1'b1;

    repeat (60) rand_cycle(1'b0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_fifo_hs.md
Name: multi_fifo_hs

Overview:
- Multi-lane synchronous FIFO for the RVV datapath. Successor to the team's multi-push/multi-pop FIFO.
- Adds per-lane valid/ready handshakes on both sides and supports non-power-of-two DEPTH with explicit pointer wrap.
- Adds a sticky protocol-error flag and an occupancy high-watermark.
- Sits between decode/issue queues and lane dispatch, where producers and consumers move a variable number of items per cycle.

Parameters:
- DW, 32, data width per lane
- M, 4, push lanes (1..DEPTH)
- N, 4, pop lanes (1..DEPTH)
- DEPTH, 12, entry count; any integer >= 2, power of two not required
- CW, $clog2(DEPTH+1), localparam, width of count/free/watermark
- PW, $clog2(DEPTH), localparam, pointer width

Ports:
- clk, in, 1, clock
- rst_n, in, 1, reset, asynchronous, active-low
- clear, in, 1, synchronous flush
- in_valid, in, M, push lane valid; must be thermometer (lane i valid implies lanes 0..i-1 valid)
- in_data, in, M*DW, lane i data at [i*DW +: DW]
- in_ready, out, M, lane i can be accepted this cycle
- out_valid, out, N, pop lane j holds valid data
- out_data, out, N*DW, lane j = j-th oldest entry
- out_ready, in, N, consumer takes lane j; must be thermometer
- count, out, CW, registered occupancy
- free, out, CW, DEPTH - count
- hwm, out, CW, max count reached since reset/clear
- err, out, 1, sticky protocol error

Behaviour:
- Reset (rst_n low, async): wptr=0, rptr=0, count=0, hwm=0, err=0.
  - Outputs during and after reset: out_valid=0, in_ready[i]=(i<DEPTH), free=DEPTH.
  - Memory contents are not reset; out_data is don't-care when out_valid=0.
- Push side:
  - in_ready[i] = (i < free_eff). Base case: free_eff = free.
  - in_ready never depends on in_valid.
  - Accepted lanes: acc_i = in_valid[i] & in_ready[i]. Push count P = popcount(acc).
  - Lane i is written to mem[(wptr+i) mod DEPTH].
  - wptr_next = (wptr+P) mod DEPTH, computed as sum with conditional subtract of DEPTH (sum < 2*DEPTH guaranteed).
- Pop side:
  - out_valid[j] = (j < count).
  - out_data[j] = mem[(rptr+j) mod DEPTH], combinational from registered state.
  - Pop count Q = popcount(out_valid & out_ready). rptr_next = (rptr+Q) mod DEPTH.
- Occupancy:
  - count_next = count + P - Q, updated every cycle.
  - Base case: P <= free and Q <= count, so no overflow or underflow is possible.
- Same-cycle push+pop: both apply; write and read indices never alias because P <= free_eff.
- Watermark: hwm_next = max(hwm, count_next), registered.
- Protocol error:
  - err sets next cycle if in_valid is non-thermometer or out_ready is non-thermometer.
  - Offending non-contiguous lanes are still handled per the acc/pop formulas (no silent repack).
  - err stays set until clear or reset.
- clear:
  - Next edge: wptr=rptr=count=hwm=0, err=0.
  - Same-cycle pushes and pops are discarded.
  - in_ready/out_valid still reflect the current state during the clear cycle.
  - clear dominates all other updates.
- Latency: a push visible on out_valid the next cycle; no same-cycle bypass from in to out.
- Full: count==DEPTH gives in_ready=0 (base mode).
- Empty: count==0 gives out_valid=0.

Optional Feature:
- Macro: MULTI_FIFO_HS_POP_FREES_EN.
- Defined:
  - free_eff = free + Q. Slots popped this cycle are reusable by pushes in the same cycle, so a full FIFO can push while popping.
  - Introduces a combinational path out_ready -> in_ready.
  - Write indices reaching (rptr+k) for k<Q are legal, since those are being read this cycle.
- Undefined: free_eff = free; no out_ready -> in_ready path.

Test Plan:
(Configuration: DW=8, M=3, N=2, DEPTH=6.)
- Reset then push in_valid=3'b111 data 1,2,3 -> in_ready=111; next cycle count=3, out_valid=11, out_data={2,1}, hwm=3.
- Fill to count=5, in_valid=111 -> in_ready=001; only lane0 accepted; count=6; next cycle in_ready=000, free=0.
- Wrap: 10 push/pop cycles with P=3, Q=2 alternating, DEPTH=6 -> data order preserved across pointer wrap (5->0); count never exceeds 6.
- count=6, out_ready=11, in_valid=111:
  - macro off -> in_ready=000, next count=4.
  - macro on -> in_ready=011, next count=6, newest two items are the pushed data.
- in_valid=3'b101 -> err=1 next cycle, stays 1; clear -> count=0, hwm=0, err=0 next cycle, pushes in the clear cycle dropped.
- Assert rst_n low mid-traffic with count=4 -> count=0, out_valid=00, err=0 immediately (async), hold through rst_n release.
